writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 51 +++++
 rtl/writeback_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path: data widths,
// the hard-wired zero register, the arbiter state encoding and the layout of
// a buffered load result.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic {
    ALU_PRI    = 1'b0,
    LOAD_FORCE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for load results waiting for a register-file write
// slot. Pointers carry one extra wrap bit so that full and empty can be told
// apart without a separate occupancy counter.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Advance the write and read pointers; overflow and underflow are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter. ALU results normally own the single
// write port; load results wait in a FIFO and are written whenever the ALU
// is idle, or forcibly after STARVE_LIMIT consecutive ALU grants. A busy-bit
// scoreboard stalls decode while a referenced register awaits a load.
// Optional feature macro: WB_BYPASS_EN adds forwarding-hit outputs that
// compare the registered write port against the decoding sources.
module writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  issue_valid,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  issue_stall,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       result
`ifdef WB_BYPASS_EN
  ,
  output logic                  bypass_rs1_hit,
  output logic                  bypass_rs2_hit,
  output logic [XLEN-1:0]       bypass_data
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;

  wb_entry_t push_entry;
  wb_entry_t head_entry;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;

  logic      alu_xfer;
  logic      mem_xfer;

  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        busy_set;
  logic        busy_clear;
  logic        wb_from_load;

  assign alu_ready  = (state == ALU_PRI) && !reset;
  assign mem_ready  = !fifo_full && !reset;
  assign alu_xfer   = alu_valid && alu_ready;
  assign mem_xfer   = mem_valid && mem_ready;
  assign push_entry = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (mem_xfer),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head     (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Arbitration state and starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ALU_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Choose who owns the write port and whether a waiting load must be forced.
  always_comb begin
    state_next  = state;
    starve_next = '0;
    fifo_pop    = 1'b0;
    case (state)
      ALU_PRI: begin
        fifo_pop = !alu_valid && !fifo_empty;
        if (alu_xfer && !fifo_empty) begin
          starve_next = starve_cnt + CNT_W'(1);
        end
        if (starve_next == LIMIT) begin
          state_next = LOAD_FORCE;
        end
      end
      LOAD_FORCE: begin
        fifo_pop   = !fifo_empty;
        state_next = ALU_PRI;
      end
      default: begin
        state_next = ALU_PRI;
      end
    endcase
  end

  // Register the write port one cycle after the granted transfer or pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable <= 1'b0;
      rd           <= '0;
      result       <= '0;
      wb_from_load <= 1'b0;
    end else if (alu_xfer) begin
      write_enable <= (alu_rd != X0);
      rd           <= alu_rd;
      result       <= alu_data;
      wb_from_load <= 1'b0;
    end else if (fifo_pop) begin
      write_enable <= (head_entry.rd != X0);
      rd           <= head_entry.rd;
      result       <= head_entry.data;
      wb_from_load <= 1'b1;
    end else begin
      write_enable <= 1'b0;
      wb_from_load <= 1'b0;
    end
  end

  // A load's register is released on the edge that commits it to the
  // register file, so decode sees the new value before it stops stalling.
  assign busy_set    = issue_valid && issue_is_load && !issue_stall && (issue_rd != X0);
  assign busy_clear  = wb_from_load && write_enable;
  assign issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]);

  // Next scoreboard value: clear first so a same-cycle set wins.
  always_comb begin
    busy_next = busy;
    if (busy_clear) begin
      busy_next[rd] = 1'b0;
    end
    if (busy_set) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

`ifdef WB_BYPASS_EN
  assign bypass_rs1_hit = write_enable && (rd == issue_rs1);
  assign bypass_rs2_hit = write_enable && (rd == issue_rs2);
  assign bypass_data    = result;
`endif

endmodule
